// File: rtl/h80cpu_uart_tx_pkg.sv
// Shared CPU bus types, UART register map and status bit positions.
package h80cpu_uart_tx_pkg;

  localparam int unsigned BUS_ADDR_W  = 16;
  localparam int unsigned BUS_DATA_W  = 16;
  localparam int unsigned BUS_CMD_W   = 2;
  localparam int unsigned UART_BYTE_W = 8;

  typedef logic [BUS_ADDR_W-1:0] bus_addr_t;
  typedef logic [BUS_DATA_W-1:0] bus_data_t;
  typedef logic [BUS_CMD_W-1:0]  bus_cmd_t;

  localparam bus_cmd_t bus_cmd_idle_b  = 2'd0;
  localparam bus_cmd_t bus_cmd_read_b  = 2'd1;
  localparam bus_cmd_t bus_cmd_write_b = 2'd2;

  localparam bus_addr_t UART_TX_DATA_ADDR = 16'h0000;
  localparam bus_addr_t UART_STATUS_ADDR  = 16'h0001;

  localparam int unsigned UART_STAT_FULL_BIT  = 0;
  localparam int unsigned UART_STAT_EMPTY_BIT = 1;
  localparam int unsigned UART_STAT_BUSY_BIT  = 2;

  // Status register word as seen on the bus.
  function automatic bus_data_t uart_status(input logic busy, input logic empty,
                                            input logic full);
    bus_data_t w;
    w = '0;
    w[UART_STAT_BUSY_BIT]  = busy;
    w[UART_STAT_EMPTY_BIT] = empty;
    w[UART_STAT_FULL_BIT]  = full;
    return w;
  endfunction

endpackage

// File: rtl/h80cpu_uart_fifo.sv
// Transmit byte FIFO, power-of-two depth, show-ahead read port.
module h80cpu_uart_fifo
  import h80cpu_uart_tx_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [UART_BYTE_W-1:0] din,
  output logic [UART_BYTE_W-1:0] dout,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [UART_BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [CW-1:0]          count;
  logic                   do_push;
  logic                   do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge sysclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/h80cpu_uart_tx.sv
// CPU-bus UART transmitter (8N1) with transmit queue.
// H80CPU_UART_TX_FIFO_EN selects the FIFO_DEPTH FIFO; otherwise a single holding register.
module h80cpu_uart_tx
  import h80cpu_uart_tx_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 27000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic      sysclk,
  input  logic      reset,
  input  logic      clk,
  input  bus_addr_t addr,
  input  bus_cmd_t  cmd,
  input  logic      run,
  input  bus_data_t wr_data,
  output bus_data_t rd_data,
  output logic      done,
  output logic      uart_txp
);

  localparam int unsigned DIV   = CLK_HZ / BAUD;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic                   prev_clk;
  logic                   bus_event_c;
  logic                   pending_c;
  logic                   is_wr_c;
  logic                   is_stat_c;
  logic                   push_c;
  logic                   pop_c;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [UART_BYTE_W-1:0] fifo_dout;
  logic                   tx_busy;
  logic                   unused_wr_hi;

  logic [1:0]             state,  state_n;
  logic [CNT_W-1:0]       cnt,    cnt_n;
  logic [2:0]             bit_idx, bit_idx_n;
  logic [UART_BYTE_W-1:0] shreg,  shreg_n;
  logic                   txp_n;
  logic                   tick_c;

  assign unused_wr_hi = ^wr_data[BUS_DATA_W-1:UART_BYTE_W];

  assign bus_event_c = ~prev_clk & clk;
  assign pending_c   = run ^ done;
  assign is_wr_c     = (cmd == bus_cmd_write_b) && (addr == UART_TX_DATA_ADDR);
  assign is_stat_c   = (cmd == bus_cmd_read_b) && (addr == UART_STATUS_ADDR);
  assign push_c      = bus_event_c & pending_c & is_wr_c & ~fifo_full;
  assign tx_busy     = (state != ST_IDLE);

  // Bus handshake: a full queue leaves a write pending so it retries on later bus events.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      prev_clk <= clk;
      done     <= 1'b0;
      rd_data  <= '0;
    end else begin
      prev_clk <= clk;
      if (bus_event_c && pending_c) begin
        if (is_wr_c) begin
          if (!fifo_full) done <= ~done;
        end else if (is_stat_c) begin
          rd_data <= uart_status(tx_busy, fifo_empty, fifo_full);
          done    <= ~done;
        end else begin
          rd_data <= '0;
          done    <= ~done;
        end
      end
    end
  end

`ifdef H80CPU_UART_TX_FIFO_EN
  h80cpu_uart_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .sysclk(sysclk),
    .reset (reset),
    .push  (push_c),
    .pop   (pop_c),
    .din   (wr_data[UART_BYTE_W-1:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
`else
  // Depth has no meaning for a single holding register.
  localparam int unsigned unused_fifo_depth = FIFO_DEPTH;

  logic                   hold_valid;
  logic [UART_BYTE_W-1:0] hold_data;

  assign fifo_full  = hold_valid;
  assign fifo_empty = ~hold_valid;
  assign fifo_dout  = hold_data;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (push_c) begin
      hold_valid <= 1'b1;
      hold_data  <= wr_data[UART_BYTE_W-1:0];
    end else if (pop_c) begin
      hold_valid <= 1'b0;
    end
  end
`endif

  assign tick_c = (cnt == CNT_W'(DIV - 1));

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      uart_txp <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_idx_n;
      shreg    <= shreg_n;
      uart_txp <= txp_n;
    end
  end

  // Frame sequencing; STOP chains straight into START when another byte is queued.
  always_comb begin
    state_n   = state;
    cnt_n     = tick_c ? '0 : cnt + CNT_W'(1);
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    txp_n     = uart_txp;
    pop_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          shreg_n = fifo_dout;
          state_n = ST_START;
          txp_n   = 1'b0;
        end
      end
      ST_START: begin
        if (tick_c) begin
          state_n   = ST_DATA;
          bit_idx_n = '0;
          txp_n     = shreg[0];
          shreg_n   = shreg >> 1;
        end
      end
      ST_DATA: begin
        if (tick_c) begin
          if (bit_idx == 3'd7) begin
            state_n = ST_STOP;
            txp_n   = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            txp_n     = shreg[0];
            shreg_n   = shreg >> 1;
          end
        end
      end
      default: begin
        if (tick_c) begin
          if (!fifo_empty) begin
            pop_c   = 1'b1;
            shreg_n = fifo_dout;
            state_n = ST_START;
            txp_n   = 1'b0;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_h80cpu_uart_tx.sv
// Scoreboard bench for h80cpu_uart_tx: bus completions and serial frames checked by monitors.
module tb_h80cpu_uart_tx;
  import h80cpu_uart_tx_pkg::*;

  localparam int CLK_HZ     = 1200000;
  localparam int BAUD       = 100000;
  localparam int DIV        = 12;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME      = 10 * DIV;
`ifdef H80CPU_UART_TX_FIFO_EN
  localparam int CAP = FIFO_DEPTH;
`else
  localparam int CAP = 1;
`endif
  localparam int NQ = (CAP >= 2) ? 2 : 1;

  logic      sysclk, reset, clk, run, done, uart_txp;
  bus_addr_t addr;
  bus_cmd_t  cmd;
  bus_data_t wr_data, rd_data;

  h80cpu_uart_tx #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .sysclk  (sysclk),
    .reset   (reset),
    .clk     (clk),
    .addr    (addr),
    .cmd     (cmd),
    .run     (run),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .done    (done),
    .uart_txp(uart_txp)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;
  initial clk = 1'b0;
  always #40 clk = ~clk;

  typedef struct {
    logic      chk;
    bus_data_t rd;
    string     name;
  } bus_exp_t;

  bus_exp_t   bus_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] burst_b [6];
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int frame_cyc = 0;
  int links = 0;
  logic in_frame = 1'b0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic finish_sim();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  endtask

  task automatic bus_issue(input bus_addr_t a, input bus_cmd_t c, input bus_data_t d,
                           input logic chk, input bus_data_t exp, input string nm);
    bus_exp_t e;
    @(negedge sysclk);
    addr    = a;
    cmd     = c;
    wr_data = d;
    e.chk = chk; e.rd = exp; e.name = nm;
    bus_q.push_back(e);
    run = ~run;
  endtask

  task automatic wait_done(input string nm);
    int t = 0;
    while (done !== run && t < 1000) begin
      @(negedge sysclk);
      t++;
    end
    if (done !== run) begin
      n_chk++;
      n_err++;
      $display("FAIL %s_timeout: done=%0b run=%0b after %0d cycles", nm, done, run, t);
      finish_sim();
    end
  endtask

  task automatic bus_req(input bus_addr_t a, input bus_cmd_t c, input bus_data_t d,
                         input logic chk, input bus_data_t exp, input string nm);
    bus_issue(a, c, d, chk, exp, nm);
    wait_done(nm);
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while ((tx_q.size() != 0 || in_frame) && t < 3000) begin
      @(negedge sysclk);
      t++;
    end
    check({nm, "_drained"}, 32'(tx_q.size() == 0 && !in_frame), 1);
  endtask

  // Completion monitor: each done toggle retires the oldest outstanding request.
  initial begin
    logic     last;
    bus_exp_t e;
    last = 1'b0;
    forever begin
      @(posedge sysclk);
      #1;
      if (reset) begin
        last = done;
      end else if (done !== last) begin
        last = done;
        if (bus_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL done_unexpected: done toggled to %0b with no request outstanding", done);
        end else begin
          e = bus_q.pop_front();
          if (e.chk) check({e.name, "_rd"}, 32'(rd_data), 32'(e.rd));
        end
      end
    end
  end

  // Serial monitor: every cycle of a frame is compared against the expected 8N1 waveform.
  initial begin
    logic [7:0] exp_b, got_b;
    logic       have, expb;
    int         bad, pos, last_start;
    last_start = -100000;
    have = 1'b0;
    bad = 0;
    forever begin
      @(posedge sysclk);
      #1;
      cyc++;
      if (reset) begin
        in_frame = 1'b0;
      end else begin
        if (!in_frame && uart_txp === 1'b0) begin
          in_frame  = 1'b1;
          frame_cyc = 0;
          bad       = 0;
          got_b     = '0;
          if (cyc == last_start + FRAME) links++;
          last_start = cyc;
          if (tx_q.size() == 0) begin
            have = 1'b0;
            n_chk++;
            n_err++;
            $display("FAIL frame_unexpected: start bit at cycle %0d, no byte queued", cyc);
          end else begin
            have  = 1'b1;
            exp_b = tx_q.pop_front();
          end
        end else if (in_frame) begin
          frame_cyc++;
        end
        if (in_frame) begin
          pos = frame_cyc / DIV;
          if (pos == 0)      expb = 1'b0;
          else if (pos <= 8) expb = exp_b[pos-1];
          else               expb = 1'b1;
          if (pos >= 1 && pos <= 8 && frame_cyc % DIV == DIV / 2) got_b[pos-1] = uart_txp;
          if (uart_txp !== expb) bad++;
          if (frame_cyc == FRAME - 1) begin
            in_frame = 1'b0;
            if (have) begin
              n_chk++;
              if (bad != 0) begin
                n_err++;
                $display("FAIL frame: got byte %02h (%0d wrong cycles) expected %02h",
                         got_b, bad, exp_b);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    n_chk++;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_sim();
  end

  initial begin
    int t;
    burst_b = '{8'h55, 8'hA3, 8'h0F, 8'hF0, 8'h81, 8'h3C};
    reset   = 1'b1;
    run     = 1'b0;
    addr    = '0;
    cmd     = bus_cmd_idle_b;
    wr_data = '0;
    repeat (4) @(negedge sysclk);
    check("rst_done", 32'(done), 0);
    check("rst_rd", 32'(rd_data), 0);
    check("rst_txp", 32'(uart_txp), 1);

    reset = 1'b0;
    repeat (5) @(negedge sysclk);
    check("idle_txp", 32'(uart_txp), 1);
    check("idle_done", 32'(done), 0);
    bus_req(UART_STATUS_ADDR, bus_cmd_read_b, '0, 1'b1, 16'h0002, "stat_idle");
    repeat (30) @(negedge sysclk);
    check("rd_hold", 32'(rd_data), 32'h2);

    // Single byte; upper write-data bits must be ignored.
    tx_q.push_back(8'h41);
    bus_req(UART_TX_DATA_ADDR, bus_cmd_write_b, 16'hAB41, 1'b0, '0, "wr_41");
    drain("frame_41");

    // Burst: CAP+1 accepted, the next one stalls until the shifter pops.
    links = 0;
    for (int i = 0; i < CAP + 1; i++) begin
      tx_q.push_back(burst_b[i]);
      bus_req(UART_TX_DATA_ADDR, bus_cmd_write_b, 16'(burst_b[i]), 1'b0, '0, "wr_burst");
    end
    tx_q.push_back(burst_b[CAP+1]);
    bus_issue(UART_TX_DATA_ADDR, bus_cmd_write_b, 16'(burst_b[CAP+1]), 1'b0, '0, "wr_stall");
    repeat (40) @(negedge sysclk);
    check("stall_held", 32'(done ^ run), 1);
    wait_done("wr_stall");
    bus_req(UART_STATUS_ADDR, bus_cmd_read_b, '0, 1'b1, 16'h0005, "stat_full");
    drain("burst");
    check("contiguous_links", 32'(links), 32'(CAP + 1));

    // Unmapped / wrong-command accesses complete with zero read data and no frame.
    bus_req(UART_STATUS_ADDR,  bus_cmd_read_b,  '0,       1'b1, 16'h0002, "stat_a");
    bus_req(UART_STATUS_ADDR,  bus_cmd_idle_b,  '0,       1'b1, 16'h0000, "idle_cmd");
    bus_req(UART_STATUS_ADDR,  bus_cmd_read_b,  '0,       1'b1, 16'h0002, "stat_b");
    bus_req(UART_TX_DATA_ADDR, bus_cmd_read_b,  '0,       1'b1, 16'h0000, "rd_data_reg");
    bus_req(UART_STATUS_ADDR,  bus_cmd_read_b,  '0,       1'b1, 16'h0002, "stat_c");
    bus_req(16'h0002,          bus_cmd_write_b, 16'h0077, 1'b1, 16'h0000, "wr_0002");
    repeat (200) @(negedge sysclk);
    check("no_frame_txp", 32'(uart_txp), 1);

    // Reset mid-frame with bytes queued behind it.
    tx_q.push_back(8'hC5);
    bus_req(UART_TX_DATA_ADDR, bus_cmd_write_b, 16'h00C5, 1'b0, '0, "wr_r0");
    tx_q.push_back(8'h5A);
    bus_req(UART_TX_DATA_ADDR, bus_cmd_write_b, 16'h005A, 1'b0, '0, "wr_r1");
    if (NQ > 1) begin
      tx_q.push_back(8'h99);
      bus_req(UART_TX_DATA_ADDR, bus_cmd_write_b, 16'h0099, 1'b0, '0, "wr_r2");
    end
    t = 0;
    while (!(in_frame && frame_cyc == 4 * DIV + 4) && t < 1000) begin
      @(negedge sysclk);
      t++;
    end
    check("reach_bit3", 32'(in_frame && frame_cyc == 4 * DIV + 4), 1);
    reset = 1'b1;
    run   = 1'b0;
    tx_q.delete();
    @(negedge sysclk);
    check("abort_txp", 32'(uart_txp), 1);
    check("abort_done", 32'(done), 0);
    repeat (2) @(negedge sysclk);
    reset = 1'b0;
    repeat (400) @(negedge sysclk);
    check("post_abort_txp", 32'(uart_txp), 1);
    bus_req(UART_STATUS_ADDR, bus_cmd_read_b, '0, 1'b1, 16'h0002, "stat_post_reset");
    repeat (5) @(negedge sysclk);
    finish_sim();
  end

endmodule
